// File: rtl/armleocpu_cache_arbiter.sv
// Two-requester arbiter in front of a single cache command port (m0 = fetch, m1 = load/store).
// The granted request is forwarded combinationally and the grant is held until the cache reports c_done.
module armleocpu_cache_arbiter #(
   parameter int ROUND_ROBIN = 1
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic [3:0]  m0_cmd,
   input  logic [31:0] m0_address,
   output logic        m0_done,

   input  logic [3:0]  m1_cmd,
   input  logic [31:0] m1_address,
   input  logic [31:0] m1_store_data,
   input  logic [3:0]  m1_store_byteenable,
   output logic        m1_done,

   output logic [3:0]  m_response,
   output logic [31:0] m_load_data,

   output logic [3:0]  c_cmd,
   output logic [31:0] c_address,
   output logic [31:0] c_store_data,
   output logic [3:0]  c_store_byteenable,
   input  logic        c_done,
   input  logic [3:0]  c_response,
   input  logic [31:0] c_load_data,

   output logic        arb_busy
);

   localparam logic [3:0] CACHE_CMD_NONE = 4'd0;

   localparam logic [0:0] STATE_IDLE = 1'b0;
   localparam logic [0:0] STATE_BUSY = 1'b1;

   logic [0:0] r_state;
   logic       r_owner;
   logic       r_last_owner;

   logic [0:0] w_state_nxt;
   logic       w_owner_nxt;
   logic       w_last_owner_nxt;
   logic       w_req0;
   logic       w_req1;
   logic       w_any_req;
   logic       w_pick;
   logic       w_owner_req;
   logic       w_fwd_en;
   logic       w_fwd_sel;
   logic       w_done0;
   logic       w_done1;

   assign w_req0      = (m0_cmd != CACHE_CMD_NONE);
   assign w_req1      = (m1_cmd != CACHE_CMD_NONE);
   assign w_any_req   = w_req0 | w_req1;
   assign w_owner_req = r_owner ? w_req1 : w_req0;

   // Select function: on a tie round-robin favours whoever was not granted last, fixed priority favours m1.
   always_comb begin
      w_pick = 1'b0;
      if (w_req0 && w_req1) begin
         if (ROUND_ROBIN != 0) begin
            w_pick = ~r_last_owner;
         end else begin
            w_pick = 1'b1;
         end
      end else if (w_req1) begin
         w_pick = 1'b1;
      end else begin
         w_pick = 1'b0;
      end
   end

   // Grant, completion routing and next-state decision.
   always_comb begin
      w_state_nxt      = r_state;
      w_owner_nxt      = r_owner;
      w_last_owner_nxt = r_last_owner;
      w_fwd_en         = 1'b0;
      w_fwd_sel        = 1'b0;
      w_done0          = 1'b0;
      w_done1          = 1'b0;
      case (r_state)
         STATE_IDLE: begin
            // A stray c_done here is a protocol violation and is deliberately not routed.
            if (w_any_req) begin
               w_fwd_en         = 1'b1;
               w_fwd_sel        = w_pick;
               w_state_nxt      = STATE_BUSY;
               w_owner_nxt      = w_pick;
               w_last_owner_nxt = w_pick;
            end else begin
               w_state_nxt = STATE_IDLE;
            end
         end
         STATE_BUSY: begin
            if (c_done) begin
               w_done0 = ~r_owner;
               w_done1 = r_owner;
               // Same-cycle re-arbitration gives back-to-back issue with no bubble.
               if (w_any_req) begin
                  w_fwd_en         = 1'b1;
                  w_fwd_sel        = w_pick;
                  w_state_nxt      = STATE_BUSY;
                  w_owner_nxt      = w_pick;
                  w_last_owner_nxt = w_pick;
               end else begin
                  w_state_nxt = STATE_IDLE;
               end
            end else if (w_owner_req) begin
               w_fwd_en    = 1'b1;
               w_fwd_sel   = r_owner;
               w_state_nxt = STATE_BUSY;
            end else begin
               w_state_nxt = STATE_IDLE;
            end
         end
         default: begin
            w_state_nxt = STATE_IDLE;
         end
      endcase
   end

   // Cache-side forwarding; everything is forced quiet while reset is held.
   always_comb begin
      c_cmd              = CACHE_CMD_NONE;
      c_address          = 32'd0;
      c_store_data       = 32'd0;
      c_store_byteenable = 4'd0;
      if (rst_n && w_fwd_en) begin
         if (w_fwd_sel) begin
            c_cmd              = m1_cmd;
            c_address          = m1_address;
            c_store_data       = m1_store_data;
            c_store_byteenable = m1_store_byteenable;
         end else begin
            c_cmd     = m0_cmd;
            c_address = m0_address;
         end
      end else begin
         c_cmd = CACHE_CMD_NONE;
      end
   end

   assign m0_done     = rst_n & w_done0;
   assign m1_done     = rst_n & w_done1;
   assign m_response  = c_response;
   assign m_load_data = c_load_data;
   assign arb_busy    = (r_state == STATE_BUSY);

   // Arbiter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= STATE_IDLE;
         r_owner      <= 1'b0;
         r_last_owner <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_owner <= w_last_owner_nxt;
      end
   end

endmodule

// File: tb/tb_armleocpu_cache_arbiter.sv
// Bench for armleocpu_cache_arbiter: one round-robin and one fixed-priority instance, each checked
// every cycle against a transaction-level model, plus directed scenarios with literal expectations.
module tb_armleocpu_cache_arbiter;

   localparam logic [3:0] NONE    = 4'd0;
   localparam logic [3:0] EXECUTE = 4'd1;
   localparam logic [3:0] LOAD    = 4'd2;

   logic        clk;
   logic        rst_n;
   logic [3:0]  m0_cmd [2];
   logic [31:0] m0_address [2];
   logic [3:0]  m1_cmd [2];
   logic [31:0] m1_address [2];
   logic [31:0] m1_store_data [2];
   logic [3:0]  m1_store_byteenable [2];
   logic        c_done [2];
   logic [3:0]  c_response [2];
   logic [31:0] c_load_data [2];

   logic        m0_done [2];
   logic        m1_done [2];
   logic [3:0]  m_response [2];
   logic [31:0] m_load_data [2];
   logic [3:0]  c_cmd [2];
   logic [31:0] c_address [2];
   logic [31:0] c_store_data [2];
   logic [3:0]  c_store_byteenable [2];
   logic        arb_busy [2];

   int checks = 0;
   int errors = 0;

   // Model: current owner (-1 when nobody holds the port) and last granted requester.
   int m_owner [2] = '{-1, -1};
   int m_last  [2] = '{0, 0};
   int pend    [2] = '{-1, -1};
   bit pend_valid [2] = '{1'b0, 1'b0};

   armleocpu_cache_arbiter #(.ROUND_ROBIN(1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .m0_cmd(m0_cmd[0]), .m0_address(m0_address[0]), .m0_done(m0_done[0]),
      .m1_cmd(m1_cmd[0]), .m1_address(m1_address[0]), .m1_store_data(m1_store_data[0]),
      .m1_store_byteenable(m1_store_byteenable[0]), .m1_done(m1_done[0]),
      .m_response(m_response[0]), .m_load_data(m_load_data[0]),
      .c_cmd(c_cmd[0]), .c_address(c_address[0]), .c_store_data(c_store_data[0]),
      .c_store_byteenable(c_store_byteenable[0]), .c_done(c_done[0]),
      .c_response(c_response[0]), .c_load_data(c_load_data[0]), .arb_busy(arb_busy[0])
   );

   armleocpu_cache_arbiter #(.ROUND_ROBIN(0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .m0_cmd(m0_cmd[1]), .m0_address(m0_address[1]), .m0_done(m0_done[1]),
      .m1_cmd(m1_cmd[1]), .m1_address(m1_address[1]), .m1_store_data(m1_store_data[1]),
      .m1_store_byteenable(m1_store_byteenable[1]), .m1_done(m1_done[1]),
      .m_response(m_response[1]), .m_load_data(m_load_data[1]),
      .c_cmd(c_cmd[1]), .c_address(c_address[1]), .c_store_data(c_store_data[1]),
      .c_store_byteenable(c_store_byteenable[1]), .c_done(c_done[1]),
      .c_response(c_response[1]), .c_load_data(c_load_data[1]), .arb_busy(arb_busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d actual=%h expected=%h t=%0t", nm, inst, act, exp, $time);
      end
   endtask

   // Instance 0 is round-robin, instance 1 fixed priority.
   function automatic int pick(int i, bit r0, bit r1);
      if (r0 && r1) return (i == 0) ? (1 - m_last[i]) : 1;
      if (r1) return 1;
      if (r0) return 0;
      return -1;
   endfunction

   // Compare process: derive expected outputs from the model and check both instances every cycle.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int g;
         bit r0, r1, e_d0, e_d1;
         logic [3:0]  e_cmd, e_be;
         logic [31:0] e_addr, e_sd;
         r0 = (m0_cmd[i] != NONE);
         r1 = (m1_cmd[i] != NONE);
         e_d0 = 1'b0;
         e_d1 = 1'b0;
         g = -1;
         if (rst_n) begin
            if (m_owner[i] < 0) begin
               g = pick(i, r0, r1);
            end else if (c_done[i]) begin
               e_d0 = (m_owner[i] == 0);
               e_d1 = (m_owner[i] == 1);
               g = pick(i, r0, r1);
            end else begin
               g = ((m_owner[i] == 0) ? r0 : r1) ? m_owner[i] : -1;
            end
         end
         e_cmd  = (g == 0) ? m0_cmd[i] : (g == 1) ? m1_cmd[i] : NONE;
         e_addr = (g == 0) ? m0_address[i] : (g == 1) ? m1_address[i] : 32'd0;
         e_sd   = (g == 1) ? m1_store_data[i] : 32'd0;
         e_be   = (g == 1) ? m1_store_byteenable[i] : 4'd0;
         chk("c_cmd", i, {28'd0, c_cmd[i]}, {28'd0, e_cmd});
         chk("c_address", i, c_address[i], e_addr);
         chk("c_store_data", i, c_store_data[i], e_sd);
         chk("c_store_byteenable", i, {28'd0, c_store_byteenable[i]}, {28'd0, e_be});
         chk("m0_done", i, {31'd0, m0_done[i]}, {31'd0, e_d0});
         chk("m1_done", i, {31'd0, m1_done[i]}, {31'd0, e_d1});
         chk("m_response", i, {28'd0, m_response[i]}, {28'd0, c_response[i]});
         chk("m_load_data", i, m_load_data[i], c_load_data[i]);
         chk("arb_busy", i, {31'd0, arb_busy[i]}, {31'd0, (rst_n && m_owner[i] >= 0)});
         pend[i]       <= g;
         pend_valid[i] <= rst_n;
      end
   end

   // Model state update: owner follows the grant computed for the cycle; reset drops it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_owner[i] <= -1;
            m_last[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (pend_valid[i]) begin
               m_owner[i] <= pend[i];
               if (pend[i] >= 0) m_last[i] <= pend[i];
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m0(logic [3:0] cmd, logic [31:0] addr);
      for (int i = 0; i < 2; i++) begin
         m0_cmd[i] = cmd;
         m0_address[i] = addr;
      end
   endtask

   task automatic set_m1(logic [3:0] cmd, logic [31:0] addr, logic [31:0] sd, logic [3:0] be);
      for (int i = 0; i < 2; i++) begin
         m1_cmd[i] = cmd;
         m1_address[i] = addr;
         m1_store_data[i] = sd;
         m1_store_byteenable[i] = be;
      end
   endtask

   task automatic set_cache(logic done, logic [3:0] resp, logic [31:0] ld);
      for (int i = 0; i < 2; i++) begin
         c_done[i] = done;
         c_response[i] = resp;
         c_load_data[i] = ld;
      end
   endtask

   task automatic do_reset();
      step();
      rst_n = 1'b0;
      set_m0(NONE, 32'd0);
      set_m1(NONE, 32'd0, 32'd0, 4'd0);
      set_cache(1'b0, 4'd0, 32'd0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic drive_random(int i);
      bit cd;
      int own;
      own = m_owner[i];
      cd = ($urandom_range(0, 99) < 35);
      c_done[i] = cd;
      c_response[i] = 4'($urandom_range(0, 15));
      c_load_data[i] = $urandom;
      if ((own == 0 && cd) || m0_cmd[i] == NONE) begin
         if ($urandom_range(0, 1) == 0) begin
            m0_cmd[i] = NONE;
         end else begin
            m0_cmd[i] = 4'($urandom_range(1, 4));
            m0_address[i] = $urandom;
         end
      end else if (own == 0 && $urandom_range(0, 99) < 2) begin
         m0_cmd[i] = NONE;
      end
      if ((own == 1 && cd) || m1_cmd[i] == NONE) begin
         if ($urandom_range(0, 1) == 0) begin
            m1_cmd[i] = NONE;
         end else begin
            m1_cmd[i] = 4'($urandom_range(1, 4));
            m1_address[i] = $urandom;
            m1_store_data[i] = $urandom;
            m1_store_byteenable[i] = 4'($urandom_range(0, 15));
         end
      end else if (own == 1 && $urandom_range(0, 99) < 2) begin
         m1_cmd[i] = NONE;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      set_m0(EXECUTE, 32'h0000_1000);
      set_m1(LOAD, 32'h0000_2000, 32'hCAFE_F00D, 4'hF);
      set_cache(1'b1, 4'd0, 32'd0);
      // Reset holds the cache side quiet even with both requesters active.
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_c_cmd", i, {28'd0, c_cmd[i]}, 32'd0);
         chk("rst_c_address", i, c_address[i], 32'd0);
         chk("rst_c_store_data", i, c_store_data[i], 32'd0);
         chk("rst_m1_done", i, {31'd0, m1_done[i]}, 32'd0);
         chk("rst_busy", i, {31'd0, arb_busy[i]}, 32'd0);
      end
      do_reset();

      // Lone fetch, completion three cycles after issue.
      set_m0(EXECUTE, 32'h0000_1000);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("t1_c_cmd", i, {28'd0, c_cmd[i]}, {28'd0, EXECUTE});
         chk("t1_c_address", i, c_address[i], 32'h0000_1000);
      end
      step();
      step();
      step();
      set_cache(1'b1, 4'd3, 32'h0000_0013);
      set_m0(NONE, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("t1_m0_done", i, {31'd0, m0_done[i]}, 32'd1);
         chk("t1_m1_done", i, {31'd0, m1_done[i]}, 32'd0);
         chk("t1_load_data", i, m_load_data[i], 32'h0000_0013);
      end
      step();
      set_cache(1'b0, 4'd0, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("t1_idle_busy", i, {31'd0, arb_busy[i]}, 32'd0);

      // Simultaneous requests right after reset: m1 wins, m0 follows with no bubble.
      do_reset();
      set_m0(EXECUTE, 32'h0000_1000);
      set_m1(LOAD, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("t2_c_address", i, c_address[i], 32'h0000_2000);
         chk("t2_c_store_data", i, c_store_data[i], 32'hDEAD_BEEF);
      end
      step();
      set_cache(1'b1, 4'd0, 32'd0);
      set_m1(NONE, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("t2_m1_done", i, {31'd0, m1_done[i]}, 32'd1);
         chk("t2_m0_done", i, {31'd0, m0_done[i]}, 32'd0);
         chk("t2_c_address_m0", i, c_address[i], 32'h0000_1000);
         chk("t2_c_store_m0", i, c_store_data[i], 32'd0);
      end
      step();
      set_cache(1'b1, 4'd0, 32'd0);
      set_m0(NONE, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("t2_m0_done_late", i, {31'd0, m0_done[i]}, 32'd1);
      step();
      set_cache(1'b0, 4'd0, 32'd0);

      // Continuous contention: round-robin alternates, fixed priority keeps m1 until it stops.
      do_reset();
      set_m0(EXECUTE, 32'h0000_1000);
      set_m1(LOAD, 32'h0000_2000, 32'd0, 4'd0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("t4_first", i, c_address[i], 32'h0000_2000);
      for (int k = 1; k <= 5; k++) begin
         step();
         set_cache(1'b1, 4'd0, 32'd0);
         if (k < 5) set_m1(LOAD, 32'h0000_2000 + 32'(4 * k), 32'd0, 4'd0);
         else set_m1(NONE, 32'd0, 32'd0, 4'd0);
         @(negedge clk);
         chk("t4_fp_m1_done", 1, {31'd0, m1_done[1]}, 32'd1);
         chk("t4_fp_addr", 1, c_address[1], (k < 5) ? 32'h0000_2000 + 32'(4 * k) : 32'h0000_1000);
         chk("t4_rr_m1_done", 0, {31'd0, m1_done[0]}, (k % 2 == 1) ? 32'd1 : 32'd0);
         chk("t4_rr_addr", 0, c_address[0], (k % 2 == 1) ? 32'h0000_1000 : 32'h0000_2000 + 32'(4 * k));
      end
      step();
      set_cache(1'b1, 4'd0, 32'd0);
      set_m0(NONE, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("t4_m0_done", i, {31'd0, m0_done[i]}, 32'd1);
      step();
      set_cache(1'b0, 4'd0, 32'd0);

      // Reset mid-transaction, then a late completion and a stray done while idle.
      do_reset();
      set_m0(EXECUTE, 32'h0000_3000);
      step();
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("t5_busy", i, {31'd0, arb_busy[i]}, 32'd1);
      step();
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("t5_rst_c_cmd", i, {28'd0, c_cmd[i]}, 32'd0);
         chk("t5_rst_busy", i, {31'd0, arb_busy[i]}, 32'd0);
      end
      step();
      set_m0(NONE, 32'd0);
      rst_n = 1'b1;
      step();
      set_cache(1'b1, 4'd0, 32'h1234_5678);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("t6_m0_done", i, {31'd0, m0_done[i]}, 32'd0);
         chk("t6_m1_done", i, {31'd0, m1_done[i]}, 32'd0);
         chk("t6_c_cmd", i, {28'd0, c_cmd[i]}, 32'd0);
      end
      step();
      set_cache(1'b0, 4'd0, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("t6_idle", i, {31'd0, arb_busy[i]}, 32'd0);

      // Randomised traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         step();
         drive_random(0);
         drive_random(1);
      end
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
